rgb_led_sched: RTL
==================

RGB_LED_SCHED -- requirements
Module: rgb_led_sched

Interface
REQ-001 Parameter NREQ, default 3: number of requesters sharing the RGB LED.
REQ-002 Parameter PWM_BITS, default 8: PWM counter and per-channel duty width.
REQ-003 Parameter DWELL, default 12000000: SHOW duration in clk cycles per grant, legal range 1 to 2^24-1.
REQ-004 Parameter GAP, default 1200000: LED-dark cycles between grants, legal range 0 to 2^24-1.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock (HFOSC domain).
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 req  input  NREQ  per-requester request level, held until done or abandoned.
REQ-009 req_color  input  NREQ*3*PWM_BITS  per-requester {R,G,B} duty; requester k occupies slice [k*3*PWM_BITS +: 3*PWM_BITS], R in MSBs.
REQ-010 grant  output  NREQ  one-hot; high for the active requester during SHOW.
REQ-011 done  output  NREQ  one-cycle pulse on requester k when its SHOW completes normally.
REQ-012 r, g, b  output  1 each  PWM drive to the RGB LED driver PWM inputs.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, SHOW and GAP.
REQ-015 A free-running PWM_BITS counter pwm_cnt SHALL increment every cycle from reset and wrap from all-ones to 0.
REQ-016 In IDLE with any req bit high, the block SHALL select the first requesting index after last_grant in round-robin order, wrapping NREQ-1 to 0.
REQ-017 On selection, the block SHALL latch that requester's color, set grant one-hot, and enter SHOW on the next edge; grant and PWM are registered and valid 1 cycle after req is sampled.
REQ-018 In SHOW, each channel output SHALL equal (pwm_cnt < latched duty): duty 0 gives constant 0, and duty all-ones gives high 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-019 Changes to req_color during SHOW SHALL have no effect.
REQ-020 grant SHALL stay high for exactly DWELL cycles; the following cycle SHALL pulse done[k] for 1 cycle, drop grant, force r/g/b to 0, update last_grant to k, and enter GAP.
REQ-021 If req[k] deasserts during SHOW, the next cycle SHALL drop grant, force r/g/b to 0, enter GAP and update last_grant to k, with no done pulse.
REQ-022 GAP SHALL hold r/g/b at 0 for GAP cycles and then return to IDLE; with GAP=0, the block SHALL go directly to IDLE in the cycle done would enter GAP.
REQ-023 Requests arriving during SHOW or GAP SHALL be held off, without loss, and arbitrated at the next IDLE cycle.
REQ-024 In IDLE and GAP, r, g, b and grant SHALL be 0.
REQ-025 The DWELL and GAP counters SHALL be 24 bits wide and SHALL never wrap within a state.

Reset
REQ-026 While rst_n is low, the block SHALL force state IDLE; grant, done, r, g, b, busy and pwm_cnt to 0; and last_grant to NREQ-1, so requester 0 wins first.
REQ-027 Reset asserted mid-SHOW or mid-GAP SHALL abort immediately, produce no done pulse, and drive all outputs to 0 asynchronously.
REQ-028 After rst_n deasserts, the first arbitration SHALL occur at the first clk edge at which req is sampled nonzero.

Verification (bench params: NREQ=3, PWM_BITS=8, DWELL=16, GAP=4)
REQ-029 Stimulus: req=3'b001, color0={8'hFF,8'h00,8'h80}. Required response: grant=001 one cycle later for 16 cycles; r low only when pwm_cnt=255; g constant 0; b high iff pwm_cnt<128; done=001 one cycle after; then 4 cycles dark, then busy=0.
REQ-030 Stimulus: req=3'b111 held continuously. Required response: grant order 001, 010, 100, 001; each grant lasts 16 cycles; consecutive grants are separated by 1 done cycle plus 4 GAP cycles.
REQ-031 Stimulus: req=3'b010 granted, then req[1] dropped after 5 SHOW cycles. Required response: grant=000 and rgb=0 on the next cycle; no done pulse; GAP lasts 4 cycles; a following req=3'b011 grants requester 0 first.
REQ-032 Stimulus: rst_n pulsed low mid-SHOW. Required response: all outputs 0 without waiting for a clk edge; after release with req=3'b110, requester 1 is granted first.
REQ-033 Stimulus: req_color changed mid-SHOW; then a GAP=0 build run. Required response: PWM duty is unchanged mid-SHOW; with GAP=0, the next grant follows the done cycle by 1 cycle.
REQ-034 Stimulus: all-zero color granted. Required response: r, g, b stay 0 for the full dwell while grant and done still behave normally.

Source files
------------

// File: rtl/rgb_led_sched.sv
// Round-robin scheduler that shares one RGB LED among NREQ requesters.
// Each grant shows its color as PWM for DWELL cycles, then the LED stays dark for GAP cycles.
module rgb_led_sched #(
    parameter int NREQ     = 3,
    parameter int PWM_BITS = 8,
    parameter int DWELL    = 12000000,
    parameter int GAP      = 1200000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*3*PWM_BITS-1:0]   req_color,
    output logic [NREQ-1:0]              grant,
    output logic [NREQ-1:0]              done,
    output logic                         r,
    output logic                         g,
    output logic                         b,
    output logic                         busy
);
    // state  | meaning
    // S_IDLE | LED dark, arbitrating among pending requests
    // S_SHOW | grant held, LED shows the latched color for DWELL cycles
    // S_GAP  | LED dark between grants; a normal finish adds its done cycle here

    localparam int          LW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int          CW       = 3 * PWM_BITS;
    localparam logic [23:0] DWELL_LD = 24'(DWELL - 1);
    localparam logic [23:0] GAP_LD   = 24'(GAP);
    localparam logic [23:0] GAP_AB   = (GAP > 0) ? 24'(GAP - 1) : 24'd0;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t                state;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [PWM_BITS-1:0]   pwm_nxt;
    logic [PWM_BITS-1:0]   duty_r, duty_g, duty_b;
    logic [23:0]           tmr;
    logic [LW-1:0]         last_grant;
    logic [LW-1:0]         cur;
    logic                  sel_valid;
    logic [LW-1:0]         sel_idx;
    logic [LW-1:0]         cand;
    logic [CW-1:0]         sel_color;

    function automatic logic [NREQ-1:0] onehot(input logic [LW-1:0] i);
        logic [NREQ-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

    assign pwm_nxt = pwm_cnt + 1'b1;
    assign busy    = (state != S_IDLE);

    // Search starts just after last_grant so every requester gets a turn.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = LW'((int'(last_grant) + i) % NREQ);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
        sel_color = req_color[sel_idx*CW +: CW];
    end

    // PWM outputs are registered against pwm_nxt so they line up with pwm_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pwm_cnt    <= '0;
            duty_r     <= '0;
            duty_g     <= '0;
            duty_b     <= '0;
            tmr        <= '0;
            last_grant <= LW'(NREQ - 1);
            cur        <= '0;
            grant      <= '0;
            done       <= '0;
            r          <= 1'b0;
            g          <= 1'b0;
            b          <= 1'b0;
        end else begin
            pwm_cnt <= pwm_nxt;
            done    <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_valid) begin
                        state  <= S_SHOW;
                        cur    <= sel_idx;
                        duty_r <= sel_color[CW-1 -: PWM_BITS];
                        duty_g <= sel_color[2*PWM_BITS-1 -: PWM_BITS];
                        duty_b <= sel_color[PWM_BITS-1:0];
                        grant  <= onehot(sel_idx);
                        tmr    <= DWELL_LD;
                        r      <= (pwm_nxt < sel_color[CW-1 -: PWM_BITS]);
                        g      <= (pwm_nxt < sel_color[2*PWM_BITS-1 -: PWM_BITS]);
                        b      <= (pwm_nxt < sel_color[PWM_BITS-1:0]);
                    end else begin
                        grant <= '0;
                        r     <= 1'b0;
                        g     <= 1'b0;
                        b     <= 1'b0;
                    end
                end
                S_SHOW: begin
                    if (!req[cur] || tmr == 24'd0) begin
                        grant      <= '0;
                        r          <= 1'b0;
                        g          <= 1'b0;
                        b          <= 1'b0;
                        last_grant <= cur;
                        state      <= (GAP == 0) ? S_IDLE : S_GAP;
                        if (!req[cur]) begin
                            tmr <= GAP_AB;
                        end else begin
                            done <= onehot(cur);
                            tmr  <= GAP_LD;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                        r   <= (pwm_nxt < duty_r);
                        g   <= (pwm_nxt < duty_g);
                        b   <= (pwm_nxt < duty_b);
                    end
                end
                S_GAP: begin
                    grant <= '0;
                    r     <= 1'b0;
                    g     <= 1'b0;
                    b     <= 1'b0;
                    if (tmr == 24'd0) begin
                        state <= S_IDLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
